// File: rtl/exp_if.sv
// exp_if: operand/result handshake bundle for the exp_taylor_seq evaluator
interface exp_if #(parameter int IN_W = 16, parameter int OUT_W = 32);
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] x;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] result;
  logic out_ovf;
  modport master (output in_valid, x, out_ready, input in_ready, out_valid, result, out_ovf);
  modport slave (input in_valid, x, out_ready, output in_ready, out_valid, result, out_ovf);
endinterface

// File: rtl/exp_taylor_seq.sv
// exp_taylor_seq: sequential fixed-point e^x, one Taylor term per clock with early exit and saturation
module exp_taylor_seq #(
  parameter int IN_W = 16,
  parameter int OUT_W = 32,
  parameter int FRAC = 8,
  parameter int N_TERMS = 10
) (
  input logic clk,
  input logic rst,
  exp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1) << FRAC;
  localparam logic [3:0] K_LAST = 4'(N_TERMS);
  state_t state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [OUT_W-1:0] term_q, term_d, sum_q, sum_d, t;
  logic [IN_W-1:0] x_q, x_d;
  logic ovf_q, ovf_d, q_ovf;
  logic [OUT_W+IN_W-1:0] p, q;
  logic [OUT_W:0] s;
  always_comb begin
    p = (OUT_W+IN_W)'(term_q) * (OUT_W+IN_W)'(x_q);
    q = p >> FRAC;
    q_ovf = |q[OUT_W+IN_W-1:OUT_W];
    // only the low word feeds the divider; when q is wider the result saturates anyway
    t = q[OUT_W-1:0] / OUT_W'(k_q);
    s = {1'b0, sum_q} + {1'b0, t};
    state_d = state_q;
    k_d = k_q;
    term_d = term_q;
    sum_d = sum_q;
    x_d = x_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.in_valid) begin
      x_d = bus.x;
      term_d = ONE;
      sum_d = ONE;
      k_d = 4'd1;
      ovf_d = 1'b0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      term_d = t;
      sum_d = s[OUT_W-1:0];
      k_d = k_q + 4'd1;
      ovf_d = ovf_q | q_ovf | s[OUT_W];
      state_d = (t == '0 || ovf_d || k_q == K_LAST) ? DONE : CALC;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      term_q <= '0;
      sum_q <= '0;
      x_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      term_q <= term_d;
      sum_q <= sum_d;
      x_q <= x_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result = state_q != DONE ? '0 : ovf_q ? '1 : sum_q;
  assign bus.out_ovf = state_q == DONE && ovf_q;
endmodule

// File: tb/tb_exp_taylor_seq.sv
// tb_exp_taylor_seq: table-driven vectors plus backpressure/reset sequences, scoreboard on results
module tb_exp_taylor_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  exp_if #(.IN_W(16), .OUT_W(32)) b();
  exp_taylor_seq #(.IN_W(16), .OUT_W(32), .FRAC(8), .N_TERMS(10)) dut (.clk(clk), .rst(rst), .bus(b));
  typedef struct {logic [31:0] res; logic ovf;} exp_t;
  typedef struct {logic [15:0] x; logic [31:0] res; logic ovf; int k;} vec_t;
  exp_t sb[$];
  vec_t vecs[7];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask
  task automatic send(input logic [15:0] xv, input logic [31:0] er, input logic eo, input int ek, input int hold);
    int n;
    exp_t e;
    logic [31:0] r0;
    n = 0;
    while (!b.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(b.in_ready), 64'd1);
    b.x = xv;
    b.in_valid = 1'b1;
    b.out_ready = 1'b0;
    sb.push_back('{res: er, ovf: eo});
    @(negedge clk);
    b.in_valid = 1'b0;
    n = 0;
    while (!b.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("latency x=%0h", xv), 64'(n), 64'(ek));
    r0 = b.result;
    for (int i = 0; i < hold; i++) begin
      b.in_valid = 1'b1;
      b.x = 16'h0200;
      @(negedge clk);
      chk("hold out_valid", 64'(b.out_valid), 64'd1);
      chk("hold result", 64'(b.result), 64'(r0));
      chk("hold in_ready", 64'(b.in_ready), 64'd0);
    end
    b.in_valid = 1'b0;
    b.out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("result x=%0h", xv), 64'(b.result), 64'(e.res));
      chk($sformatf("out_ovf x=%0h", xv), 64'(b.out_ovf), 64'(e.ovf));
    end
    @(negedge clk);
    b.out_ready = 1'b0;
    chk("post out_valid", 64'(b.out_valid), 64'd0);
    chk("post in_ready", 64'(b.in_ready), 64'd1);
  endtask
  initial begin
    vecs[0] = '{x: 16'h0000, res: 32'd256, ovf: 1'b0, k: 1};
    vecs[1] = '{x: 16'h0100, res: 32'd694, ovf: 1'b0, k: 6};
    vecs[2] = '{x: 16'h0200, res: 32'd1888, ovf: 1'b0, k: 9};
    vecs[3] = '{x: 16'hFFFF, res: 32'hFFFF_FFFF, ovf: 1'b1, k: 4};
    vecs[4] = '{x: 16'h0080, res: 32'd421, ovf: 1'b0, k: 4};
    vecs[5] = '{x: 16'h0001, res: 32'd257, ovf: 1'b0, k: 2};
    vecs[6] = '{x: 16'h0400, res: 32'd13933, ovf: 1'b0, k: 10};
    b.in_valid = 1'b0;
    b.x = '0;
    b.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 64'(b.in_ready), 64'd1);
    chk("reset out_valid", 64'(b.out_valid), 64'd0);
    chk("reset result", 64'(b.result), 64'd0);
    chk("reset out_ovf", 64'(b.out_ovf), 64'd0);
    foreach (vecs[i]) send(vecs[i].x, vecs[i].res, vecs[i].ovf, vecs[i].k, 0);
    send(16'h0100, 32'd694, 1'b0, 6, 5);
    send(16'h0000, 32'd256, 1'b0, 1, 0);
    b.x = 16'h0200;
    b.in_valid = 1'b1;
    @(negedge clk);
    b.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midcalc in_ready", 64'(b.in_ready), 64'd1);
    chk("midcalc out_valid", 64'(b.out_valid), 64'd0);
    chk("midcalc result", 64'(b.result), 64'd0);
    chk("midcalc out_ovf", 64'(b.out_ovf), 64'd0);
    send(16'h0100, 32'd694, 1'b0, 6, 0);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exp_taylor_seq.md
Name: exp_taylor_seq

Overview:
- Sequential, parametrised unsigned fixed-point e^x evaluator using a truncated Taylor series.
- Computes one series term per clock, so a single multiplier and a small-constant divider replace the fully unrolled combinational evaluator.
- Adds a valid/ready handshake, early termination when a term truncates to zero, and overflow saturation with a flag.
- Sits behind an input register stage in the math datapath and feeds downstream consumers through out_valid/out_ready.

Parameters:
- IN_W, 16, width of unsigned operand x (fixed point, FRAC fractional bits).
- OUT_W, 32, width of result and of internal term/sum registers (FRAC fractional bits).
- FRAC, 8, number of fractional bits shared by x, terms and result.
- N_TERMS, 10, maximum series order computed (k = 1..N_TERMS); legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand x is valid.
- in_ready  out  1  block can accept an operand (high only in IDLE).
- x  in  IN_W  unsigned operand, FRAC fractional bits.
- out_valid  out  1  result and out_ovf are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  OUT_W  e^x, FRAC fractional bits; all-ones when saturated.
- out_ovf  out  1  overflow occurred; result is saturated.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE; in_ready=1, out_valid=0, result=0, out_ovf=0; internal k, term, sum, x_reg and ovf all cleared. A transaction in flight when reset arrives is discarded.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - capture x_reg=x;
  - term=1<<FRAC, sum=1<<FRAC, k=1, ovf=0;
  - go to CALC.
- CALC: in_ready=0. Each cycle:
  - p = term*x_reg (OUT_W+IN_W bits).
  - q = p>>FRAC. If q exceeds OUT_W bits, set ovf.
  - t = q/k, integer truncating division.
  - s = sum+t at OUT_W+1 bits. If s overflows OUT_W bits, set ovf.
  - Register term=t, sum=s[OUT_W-1:0], k=k+1.
  - Go to DONE when t==0, ovf is set, or k==N_TERMS. Otherwise stay in CALC.
- DONE: out_valid=1.
  - result = ovf ? all-ones : sum; out_ovf = ovf.
  - result and out_ovf stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE; out_valid drops next cycle.
  - A new operand cannot be accepted in the same cycle as the result handshake. The next accept is at the earliest one cycle after.
- Latency: operand accepted at edge T. With K CALC cycles (1 ≤ K ≤ N_TERMS), out_valid is first high after edge T+K. Early exit produces a result bit-identical to a full N_TERMS run, because all later terms are 0.
- Arithmetic: everything is unsigned, and every division truncates. Series order is term_k = ((term_{k-1}*x)>>FRAC)/k. No factorial table is used.
- x=0: first term is 0, so K=1 and result=1<<FRAC.
- in_valid while busy: ignored (in_ready=0); the source must hold its data.
- out_ready while out_valid=0: no effect.

Test Plan:
- Reset, then x=0 with out_ready=1: result=256, out_ovf=0, out_valid one cycle after the single CALC cycle; in_ready=1 again after the handshake.
- x=256 (1.0): terms 256,128,42,10,2,0 give result=694 after K=6 CALC cycles.
- x=512 (2.0): terms 512,512,341,170,68,22,6,1,0 give result=1888 after K=9 CALC cycles, out_ovf=0.
- x=0xFFFF: overflow at k=4 gives result=0xFFFFFFFF, out_ovf=1, DONE after the fourth CALC cycle.
- Backpressure: x=256, out_ready held 0 for 5 cycles.
  - out_valid stays 1 and result=694 stays stable.
  - in_ready stays 0; a second in_valid is ignored.
  - Releasing out_ready completes the handshake, and the next x=0 returns 256.
- Reset mid-CALC: start x=512, assert rst at the third CALC cycle.
  - Next cycle shows IDLE, in_ready=1, out_valid=0, result=0, out_ovf=0.
  - A fresh x=256 then returns 694.
